// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the hazard/forwarding controller.
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

  localparam logic [1:0] FwdRf  = 2'b00;
  localparam logic [1:0] FwdWb  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  // MEM beats WB so the youngest producer wins.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) begin
      return FwdMem;
    end else if (wb_hit) begin
      return FwdWb;
    end
    return FwdRf;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: {valid, rs, rt, writereg, regwrite, memtoreg}.
// A bubble loads an all-zero entry so stale register numbers never match.
module hazard_stage_reg #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] writereg_i,
  input  logic              regwrite_i,
  input  logic              memtoreg_i,
  output logic              valid_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] writereg_o,
  output logic              regwrite_o,
  output logic              memtoreg_o
);

  logic              valid_d, valid_q;
  logic [REG_AW-1:0] rs_d, rs_q, rt_d, rt_q, writereg_d, writereg_q;
  logic              regwrite_d, regwrite_q, memtoreg_d, memtoreg_q;

  always_comb begin
    valid_d    = valid_i;
    rs_d       = rs_i;
    rt_d       = rt_i;
    writereg_d = writereg_i;
    regwrite_d = regwrite_i;
    memtoreg_d = memtoreg_i;
    if (bubble_i) begin
      valid_d    = 1'b0;
      rs_d       = '0;
      rt_d       = '0;
      writereg_d = '0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      writereg_q <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      writereg_q <= writereg_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  assign valid_o    = valid_q;
  assign rs_o       = rs_q;
  assign rt_o       = rt_q;
  assign writereg_o = writereg_q;
  assign regwrite_o = regwrite_q;
  assign memtoreg_o = memtoreg_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Define BRANCH_FWD_EN to enable ID-stage branch-compare forwarding and branch stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] writereg_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              branch_d,
  output logic [1:0]        forwardae,
  output logic [1:0]        forwardbe,
  output logic              forwardad,
  output logic              forwardbd,
  output logic              stallf,
  output logic              stalld,
  output logic              flushe,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              e_valid, m_valid, w_valid;
  logic [REG_AW-1:0] e_rs, m_rs, w_rs, e_rt, m_rt, w_rt;
  logic [REG_AW-1:0] e_writereg, m_writereg, w_writereg;
  logic              e_regwrite, m_regwrite, w_regwrite;
  logic              e_memtoreg, m_memtoreg, w_memtoreg;
  logic              stall, lwstall, brstall, hazard;
  logic              m_fwd_ok, w_fwd_ok;
  state_e            state_d, state_q;
  logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;

  hazard_stage_reg #(.REG_AW(REG_AW)) u_stage_e (
    .clk_i      (clk),
    .rst_i      (rst),
    .bubble_i   (stall),
    .valid_i    (valid_d),
    .rs_i       (rs_d),
    .rt_i       (rt_d),
    .writereg_i (writereg_d),
    .regwrite_i (regwrite_d),
    .memtoreg_i (memtoreg_d),
    .valid_o    (e_valid),
    .rs_o       (e_rs),
    .rt_o       (e_rt),
    .writereg_o (e_writereg),
    .regwrite_o (e_regwrite),
    .memtoreg_o (e_memtoreg)
  );

  hazard_stage_reg #(.REG_AW(REG_AW)) u_stage_m (
    .clk_i      (clk),
    .rst_i      (rst),
    .bubble_i   (1'b0),
    .valid_i    (e_valid),
    .rs_i       (e_rs),
    .rt_i       (e_rt),
    .writereg_i (e_writereg),
    .regwrite_i (e_regwrite),
    .memtoreg_i (e_memtoreg),
    .valid_o    (m_valid),
    .rs_o       (m_rs),
    .rt_o       (m_rt),
    .writereg_o (m_writereg),
    .regwrite_o (m_regwrite),
    .memtoreg_o (m_memtoreg)
  );

  hazard_stage_reg #(.REG_AW(REG_AW)) u_stage_w (
    .clk_i      (clk),
    .rst_i      (rst),
    .bubble_i   (1'b0),
    .valid_i    (m_valid),
    .rs_i       (m_rs),
    .rt_i       (m_rt),
    .writereg_i (m_writereg),
    .regwrite_i (m_regwrite),
    .memtoreg_i (m_memtoreg),
    .valid_o    (w_valid),
    .rs_o       (w_rs),
    .rt_o       (w_rt),
    .writereg_o (w_writereg),
    .regwrite_o (w_regwrite),
    .memtoreg_o (w_memtoreg)
  );

  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  assign m_fwd_ok = m_valid & m_regwrite & (m_writereg != '0);
  assign w_fwd_ok = w_valid & w_regwrite & (w_writereg != '0);

  assign forwardae = fwd_sel(m_fwd_ok & (m_writereg == e_rs), w_fwd_ok & (w_writereg == e_rs));
  assign forwardbe = fwd_sel(m_fwd_ok & (m_writereg == e_rt), w_fwd_ok & (w_writereg == e_rt));

  assign lwstall = valid_d & e_valid & e_memtoreg & (e_writereg != '0) &
                   ((e_writereg == rs_d) | (e_writereg == rt_d));

`ifdef BRANCH_FWD_EN
  logic unused_sigs;
  assign unused_sigs = ^{m_rs, m_rt, w_rs, w_rt, w_memtoreg};

  assign forwardad = m_fwd_ok & (m_writereg == rs_d);
  assign forwardbd = m_fwd_ok & (m_writereg == rt_d);
  assign brstall   = valid_d & branch_d &
                     ((e_valid & e_regwrite & (e_writereg != '0) &
                       ((e_writereg == rs_d) | (e_writereg == rt_d))) |
                      (m_valid & m_memtoreg & (m_writereg != '0) &
                       ((m_writereg == rs_d) | (m_writereg == rt_d))));
`else
  logic unused_sigs;
  assign unused_sigs = ^{m_rs, m_rt, w_rs, w_rt, w_memtoreg, m_memtoreg, e_regwrite, branch_d};

  assign forwardad = 1'b0;
  assign forwardbd = 1'b0;
  assign brstall   = 1'b0;
`endif

  assign hazard = lwstall | brstall;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (hazard) begin
          state_d = StStall;
          stall   = 1'b1;
        end
      end
      StStall: begin
        // The producer has advanced one stage; re-check before resuming.
        stall   = hazard;
        state_d = hazard ? StStall : StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallf    = stall;
  assign stalld    = stall;
  assign flushe    = stall;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (default build, BRANCH_FWD_EN undefined).
module tb_hazard_ctrl;

  localparam int CntW   = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_d, regwrite_d, memtoreg_d, branch_d;
  logic [4:0]      rs_d, rt_d, writereg_d;
  logic [1:0]      forwardae, forwardbe;
  logic            forwardad, forwardbd, stallf, stalld, flushe;
  logic [CntW-1:0] stall_cnt;

  hazard_ctrl #(.REG_AW(5), .CNT_W(CntW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_d    (valid_d),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .writereg_d (writereg_d),
    .regwrite_d (regwrite_d),
    .memtoreg_d (memtoreg_d),
    .branch_d   (branch_d),
    .forwardae  (forwardae),
    .forwardbe  (forwardbe),
    .forwardad  (forwardad),
    .forwardbd  (forwardbd),
    .stallf     (stallf),
    .stalld     (stalld),
    .flushe     (flushe),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [4:0] rs, rt, wr;
    bit         rw, mr;
  } ins_t;

  // In-flight instructions, youngest first: [0]=EX, [1]=MEM, [2]=WB.
  ins_t pipe[$];
  ins_t cur;
  int   exp_cnt;
  bit   last_stall;
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(bit v, int rs, int rt, int wr, bit rw, bit mr);
    ins_t i;
    i.v  = v;
    i.rs = 5'(rs);
    i.rt = 5'(rt);
    i.wr = 5'(wr);
    i.rw = rw;
    i.mr = mr;
    return i;
  endfunction

  function automatic ins_t bubble();
    return mk(0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit produces(ins_t p, logic [4:0] src);
    return p.v && p.rw && (p.wr != 0) && (p.wr == src);
  endfunction

  function automatic int exp_fwd(logic [4:0] src);
    if (produces(pipe[1], src)) return 2;
    if (produces(pipe[2], src)) return 1;
    return 0;
  endfunction

  function automatic bit exp_lwstall();
    ins_t e = pipe[0];
    return cur.v && e.v && e.mr && (e.wr != 0) && ((e.wr == cur.rs) || (e.wr == cur.rt));
  endfunction

  function automatic void model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(bubble());
    exp_cnt    = 0;
    last_stall = 0;
  endfunction

  // Called just after a falling edge: drive cur, compare, then advance one cycle.
  task automatic step(input bit r);
    bit s;
    rst        = r;
    valid_d    = cur.v;
    rs_d       = cur.rs;
    rt_d       = cur.rt;
    writereg_d = cur.wr;
    regwrite_d = cur.rw;
    memtoreg_d = cur.mr;
    branch_d   = 1'($urandom_range(0, 1));
    #1;
    s = exp_lwstall();
    check_eq("stallf", stallf, s);
    check_eq("stalld", stalld, s);
    check_eq("flushe", flushe, s);
    check_eq("forwardae", forwardae, exp_fwd(pipe[0].rs));
    check_eq("forwardbe", forwardbe, exp_fwd(pipe[0].rt));
    check_eq("forwardad", forwardad, 0);
    check_eq("forwardbd", forwardbd, 0);
    check_eq("stall_cnt", stall_cnt, exp_cnt);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      pipe.push_front(s ? bubble() : cur);
      void'(pipe.pop_back());
      if (s && exp_cnt < CntMax) exp_cnt++;
      last_stall = s;
    end
    @(negedge clk);
  endtask

  // Present one instruction, holding it in ID for as long as the model stalls.
  task automatic issue(input ins_t i);
    cur = i;
    step(0);
    for (int k = 0; k < 4 && last_stall; k++) step(0);
  endtask

  task automatic do_reset();
    cur = bubble();
    step(1);
  endtask

  // Drive the next instruction and compare an output before the cycle is stepped.
  task automatic peek(input ins_t i);
    cur        = i;
    rst        = 1'b0;
    valid_d    = i.v;
    rs_d       = i.rs;
    rt_d       = i.rt;
    writereg_d = i.wr;
    regwrite_d = i.rw;
    memtoreg_d = i.mr;
    #1;
  endtask

  initial begin
    ins_t nop;
    nop = bubble();
    cur = nop;
    rst = 1'b1;
    valid_d = 0; rs_d = 0; rt_d = 0; writereg_d = 0;
    regwrite_d = 0; memtoreg_d = 0; branch_d = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();

    // Reset state
    peek(nop);
    check_eq("rst_fwd_a", forwardae, 0);
    check_eq("rst_stall", stallf, 0);
    check_eq("rst_cnt", stall_cnt, 0);

    // 1: add $3 in M, reader in E -> MEM forward on srcA only
    issue(mk(1, 1, 2, 3, 1, 0));
    issue(mk(1, 3, 4, 6, 1, 0));
    peek(nop);
    check_eq("t1_fwd_a", forwardae, 2);
    check_eq("t1_fwd_b", forwardbe, 0);
    check_eq("t1_stall", stallf, 0);
    issue(nop);

    // 2: add $3, nop, sub rs=$3 -> WB forward; with $3 also in M -> MEM wins
    issue(mk(1, 1, 2, 3, 1, 0));
    issue(nop);
    issue(mk(1, 3, 0, 7, 1, 0));
    peek(nop);
    check_eq("t2_fwd_wb", forwardae, 1);
    issue(mk(1, 1, 2, 3, 1, 0));
    issue(mk(1, 1, 2, 3, 1, 0));
    issue(mk(1, 3, 0, 7, 1, 0));
    peek(nop);
    check_eq("t2_fwd_mem", forwardae, 2);
    issue(nop);

    // 3: lw $5 then add rt=$5 -> one stall, then WB forward on srcB
    do_reset();
    issue(mk(1, 1, 5, 5, 1, 1));
    peek(mk(1, 2, 5, 8, 1, 0));
    check_eq("t3_stallf", stallf, 1);
    check_eq("t3_stalld", stalld, 1);
    check_eq("t3_flushe", flushe, 1);
    issue(mk(1, 2, 5, 8, 1, 0));
    peek(nop);
    check_eq("t3_fwd_b", forwardbe, 1);
    check_eq("t3_cnt", stall_cnt, 1);
    issue(nop);

    // 4: writes to $0 in M and W never forward
    issue(mk(1, 1, 2, 0, 1, 0));
    issue(mk(1, 1, 2, 0, 1, 1));
    issue(mk(1, 0, 0, 9, 1, 0));
    peek(nop);
    check_eq("t4_fwd_a", forwardae, 0);
    check_eq("t4_fwd_b", forwardbe, 0);
    check_eq("t4_stall", stallf, 0);
    issue(nop);

    // 5: reset asserted in the middle of a load-use stall
    issue(mk(1, 1, 2, 5, 1, 1));
    cur = mk(1, 5, 1, 8, 1, 0);
    step(1);
    peek(nop);
    check_eq("t5_stall", stallf, 0);
    check_eq("t5_flushe", flushe, 0);
    check_eq("t5_fwd_a", forwardae, 0);
    check_eq("t5_cnt", stall_cnt, 0);

    // Load-use with an invalid reader must not stall
    issue(mk(1, 1, 2, 5, 1, 1));
    peek(mk(0, 5, 5, 1, 1, 0));
    check_eq("inv_nostall", stallf, 0);
    issue(nop);

    // Counter saturation
    do_reset();
    for (int n = 0; n < CntMax + 3; n++) begin
      issue(mk(1, 0, 0, 6, 1, 1));
      issue(mk(1, 6, 0, 2, 1, 0));
    end
    peek(nop);
    check_eq("sat_cnt", stall_cnt, CntMax);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        bit mr = ($urandom_range(0, 2) == 0);
        cur = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), mr | 1'($urandom_range(0, 1)), mr);
      end
      step($urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
